// File: rtl/pir_alarm_axi_regs.sv
// PIR motion alarm with an AXI4-Lite register block.
// Motion events set a sticky flag, bump a saturating event counter and
// (optionally) restart a buzzer countdown. Software sees CTRL/STATUS/COUNT/
// BUZZ_LEN through a minimal single-beat AXI4-Lite slave.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for awvalid and wvalid together
//   W_ACK  | awready/wready high, register updated at end of cycle
//   W_RESP | bvalid high until bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for arvalid
//   R_ACK  | arready high, rdata captured at end of cycle
//   R_DATA | rvalid high with stable rdata until rready
module pir_alarm_axi_regs #(
    parameter logic [31:0] BUZZ_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        motion_pulse,
    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        led,
    output logic        buzzer,
    output logic        irq
);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t    r_wstate, w_wstate_nxt;
    r_state_t    r_rstate, w_rstate_nxt;

    logic [2:0]  r_ctrl;          // {irq_en, buzz_en, arm}
    logic        r_flag;
    logic [15:0] r_count;
    logic [31:0] r_buzz_len;
    logic [31:0] r_countdown;
    logic [31:0] r_rdata;

    logic        w_wr_en;
    logic [1:0]  w_wr_word;
    logic        w_event;
    logic        w_ctrl_wr;
    logic        w_w1c;
    logic        w_count_wr;
    logic        w_len_wr;
    logic        w_cd_clear;
    logic        w_buzz_active;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    // Byte-lane address bits carry no information for word registers.
    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state and handshake outputs
    always_comb begin
        w_wstate_nxt  = r_wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_wstate_nxt = W_ACK;
            W_ACK: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                w_wstate_nxt  = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: if (s_axi_arvalid) w_rstate_nxt = R_ACK;
            R_ACK: begin
                s_axi_arready = 1'b1;
                w_rstate_nxt  = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_wr_en       = (r_wstate == W_ACK);
    assign w_wr_word     = s_axi_awaddr[3:2];
    assign w_event       = motion_pulse & r_ctrl[0];
    assign w_ctrl_wr     = w_wr_en && (w_wr_word == 2'd0) && s_axi_wstrb[0];
    assign w_w1c         = w_wr_en && (w_wr_word == 2'd1) && s_axi_wstrb[0] && s_axi_wdata[0];
    assign w_count_wr    = w_wr_en && (w_wr_word == 2'd2);
    assign w_len_wr      = w_wr_en && (w_wr_word == 2'd3);
    assign w_buzz_active = (r_countdown != 32'd0);

    // The buzzer stops when the flag really clears (a coincident event keeps
    // it set) or when software disarms / disables the buzzer.
    assign w_cd_clear = (w_w1c && !w_event) ||
                        (w_ctrl_wr && (!s_axi_wdata[0] || !s_axi_wdata[1]));

    // CTRL register
    always_ff @(posedge clk) begin
        if (!rst_n)         r_ctrl <= 3'd0;
        else if (w_ctrl_wr) r_ctrl <= s_axi_wdata[2:0];
    end

    // Sticky motion flag: set beats write-1-to-clear
    always_ff @(posedge clk) begin
        if (!rst_n)       r_flag <= 1'b0;
        else if (w_event) r_flag <= 1'b1;
        else if (w_w1c)   r_flag <= 1'b0;
    end

    // Saturating event counter: a write clear beats an increment
    always_ff @(posedge clk) begin
        if (!rst_n)                                  r_count <= 16'd0;
        else if (w_count_wr)                         r_count <= 16'd0;
        else if (w_event && (r_count != 16'hFFFF))   r_count <= r_count + 16'd1;
    end

    // BUZZ_LEN register with byte strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buzz_len <= BUZZ_CYCLES;
        end else if (w_len_wr) begin
            for (int i = 0; i < 4; i++)
                if (s_axi_wstrb[i]) r_buzz_len[8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
    end

    // Buzzer down-counter: clear, reload on event, else run down to zero
    always_ff @(posedge clk) begin
        if (!rst_n)                    r_countdown <= 32'd0;
        else if (w_cd_clear)           r_countdown <= 32'd0;
        else if (w_event && r_ctrl[1]) r_countdown <= r_buzz_len;
        else if (w_buzz_active)        r_countdown <= r_countdown - 32'd1;
    end

    // Read data mux over the four mapped words
    always_comb begin
        w_rd_mux = 32'd0;
        case (s_axi_araddr[3:2])
            2'd0: w_rd_mux = {29'd0, r_ctrl};
            2'd1: w_rd_mux = {30'd0, w_buzz_active, r_flag};
            2'd2: w_rd_mux = {16'd0, r_count};
            2'd3: w_rd_mux = r_buzz_len;
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Read data capture; it samples pre-write values when a write commits
    // on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n)                  r_rdata <= 32'd0;
        else if (r_rstate == R_ACK)  r_rdata <= w_rd_mux;
    end

    assign s_axi_rdata = r_rdata;
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign led         = r_flag;
    assign buzzer      = w_buzz_active;
    assign irq         = r_flag & r_ctrl[2];

endmodule

// File: tb/tb_pir_alarm_axi_regs.sv
// Self-checking bench for pir_alarm_axi_regs: directed scenarios plus a
// randomized phase, all compared against a timestamp-based behavioural model.
module tb_pir_alarm_axi_regs;

    localparam logic [31:0] BUZZ_RST = 32'd50_000_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        motion_pulse = 1'b0;
    logic [3:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        led, buzzer, irq;

    pir_alarm_axi_regs #(.BUZZ_CYCLES(BUZZ_RST)) dut (
        .clk(clk), .rst_n(rst_n), .motion_pulse(motion_pulse),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .led(led), .buzzer(buzzer), .irq(irq)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    // Behavioural model: the buzzer is described by the cycle index at which
    // it goes quiet, not by a counter.
    logic [2:0]  m_ctrl;
    logic        m_flag;
    int          m_count;
    logic [31:0] m_buzz_len;
    longint      m_stop;

    task automatic model_reset();
        m_ctrl = 3'd0; m_flag = 1'b0; m_count = 0; m_buzz_len = BUZZ_RST; m_stop = 0;
    endtask

    function automatic logic m_buzz();
        return (cyc < m_stop);
    endfunction

    // Apply everything that happened at the edge just taken.
    task automatic model_commit(input bit wr, input logic [3:0] a, input logic [31:0] d,
                                input logic [3:0] s, input bit p);
        bit ev;
        logic [31:0] old_len;
        ev = p && m_ctrl[0];
        old_len = m_buzz_len;
        if (ev) begin
            m_flag = 1'b1;
            m_count = (m_count + 1 > 65535) ? 65535 : m_count + 1;
            if (m_ctrl[1]) m_stop = cyc + longint'(old_len);
        end
        if (wr) begin
            case (a[3:2])
                2'd0: if (s[0]) begin
                    m_ctrl = d[2:0];
                    if (!d[0] || !d[1]) m_stop = cyc;
                end
                2'd1: if (s[0] && d[0] && !ev) begin
                    m_flag = 1'b0;
                    m_stop = cyc;
                end
                2'd2: m_count = 0;
                default: for (int b = 0; b < 4; b++)
                    if (s[b]) m_buzz_len[8*b +: 8] = d[8*b +: 8];
            endcase
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return {30'd0, m_buzz(), m_flag};
            2'd2:    return 32'(m_count);
            default: return m_buzz_len;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_led"}, {31'd0, led}, {31'd0, m_flag});
        chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_flag & m_ctrl[2]});
        chk({tag, "_buzzer"}, {31'd0, buzzer}, {31'd0, m_buzz()});
    endtask

    task automatic pulse();
        motion_pulse = 1'b1;
        tick();
        motion_pulse = 1'b0;
        model_commit(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
    endtask

    // Full write; p puts a motion pulse on the committing edge.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input bit p);
        int n;
        n = 0;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        tick();
        while (!s_axi_awready && n < 20) begin tick(); n++; end
        chk("wr_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("wr_wready", {31'd0, s_axi_wready}, 32'd1);
        motion_pulse = p;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; motion_pulse = 1'b0;
        model_commit(1'b1, a, d, s, p);
        chk("wr_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        chk("wr_bresp", {30'd0, s_axi_bresp}, 32'd0);
        tick();
        chk("wr_bvalid_drop", {31'd0, s_axi_bvalid}, 32'd0);
        s_axi_bready = 1'b0;
    endtask

    // Full read; returns data and the model's expectation at capture time.
    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [31:0] e);
        int n;
        n = 0;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        tick();
        while (!s_axi_arready && n < 20) begin tick(); n++; end
        chk("rd_arready", {31'd0, s_axi_arready}, 32'd1);
        e = exp_read(a);
        tick();
        s_axi_arvalid = 1'b0;
        chk("rd_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        chk("rd_rresp", {30'd0, s_axi_rresp}, 32'd0);
        d = s_axi_rdata;
        s_axi_rready = 1'b1;
        tick();
        chk("rd_rvalid_drop", {31'd0, s_axi_rvalid}, 32'd0);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d, e;
        logic [3:0]  ra, rs;
        logic [31:0] rd;
        bit          rp;
        int          op;

        model_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("rst_wready", {31'd0, s_axi_wready}, 32'd0);
        chk("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk_outputs("rst");
        axi_read(4'hC, d, e);
        chk("rst_buzz_len", d, BUZZ_RST);
        axi_read(4'h0, d, e);
        chk("rst_ctrl", d, 32'd0);

        // Armed event with a 10-cycle buzz
        axi_write(4'h0, 32'h7, 4'hF, 1'b0);
        axi_write(4'hC, 32'd10, 4'hF, 1'b0);
        pulse();
        for (int i = 0; i < 12; i++) begin
            chk("buzz_window", {31'd0, buzzer}, (i < 10) ? 32'd1 : 32'd0);
            tick();
        end
        chk("ev_led", {31'd0, led}, 32'd1);
        chk("ev_irq", {31'd0, irq}, 32'd1);
        axi_read(4'h8, d, e);
        chk("ev_count", d, 32'd1);

        // Disarmed pulses are ignored
        axi_write(4'h4, 32'h1, 4'hF, 1'b0);
        axi_write(4'h8, 32'h0, 4'hF, 1'b0);
        axi_write(4'h0, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) pulse();
        axi_read(4'h4, d, e);
        chk("disarm_status", d, 32'd0);
        axi_read(4'h8, d, e);
        chk("disarm_count", d, 32'd0);
        chk("disarm_buzzer", {31'd0, buzzer}, 32'd0);
        chk("disarm_irq", {31'd0, irq}, 32'd0);

        // Event coincident with W1C: set wins
        axi_write(4'h0, 32'h7, 4'hF, 1'b0);
        axi_write(4'h4, 32'h1, 4'hF, 1'b1);
        axi_read(4'h4, d, e);
        chk("w1c_race_flag", {31'd0, d[0]}, 32'd1);
        chk("w1c_race_model", d, e);
        chk("w1c_race_led", {31'd0, led}, 32'd1);

        // Concurrent read and write of BUZZ_LEN: read sees the old value
        s_axi_awaddr = 4'hC; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_araddr = 4'hC;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        tick();
        chk("conc_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("conc_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        model_commit(1'b1, 4'hC, 32'h55, 4'hF, 1'b0);
        chk("conc_rdata_old", s_axi_rdata, 32'd10);
        chk("conc_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        chk("conc_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        chk("conc_bvalid_drop", {31'd0, s_axi_bvalid}, 32'd0);
        axi_read(4'hC, d, e);
        chk("conc_new_len", d, 32'h55);

        // awvalid alone stalls; bvalid held until bready
        s_axi_awaddr = 4'h0; s_axi_wdata = 32'h3; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_awready", {31'd0, s_axi_awready}, 32'd0);
        end
        s_axi_wvalid = 1'b1;
        tick();
        chk("stall_accept", {31'd0, s_axi_awready}, 32'd1);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        model_commit(1'b1, 4'h0, 32'h3, 4'hF, 1'b0);
        chk("stall_awready_once", {31'd0, s_axi_awready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
            chk("hold_bresp", {30'd0, s_axi_bresp}, 32'd0);
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk("hold_bvalid_drop", {31'd0, s_axi_bvalid}, 32'd0);
        chk_outputs("after_stall");

        // Randomized mix against the model
        axi_write(4'hC, 32'd6, 4'hF, 1'b0);
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                pulse();
            end else if (op <= 5) begin
                ra = 4'($urandom_range(0, 15));
                rd = $urandom;
                rs = 4'($urandom_range(0, 15));
                rp = 1'($urandom_range(0, 1));
                if (ra[3:2] == 2'd3) rd = rd & 32'h0000_001F;
                axi_write(ra, rd, rs, rp);
            end else if (op <= 8) begin
                ra = 4'($urandom_range(0, 15));
                axi_read(ra, d, e);
                chk("rand_read", d, e);
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 8)); k++) tick();
            end
            chk_outputs("rand");
        end

        // Counter saturation then write-clear
        axi_write(4'h0, 32'h1, 4'hF, 1'b0);
        axi_write(4'h8, 32'h0, 4'hF, 1'b0);
        motion_pulse = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick();
            model_commit(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        end
        motion_pulse = 1'b0;
        axi_read(4'h8, d, e);
        chk("sat_count", d, 32'h0000_FFFF);
        axi_write(4'h8, 32'h1234, 4'hF, 1'b0);
        axi_read(4'h8, d, e);
        chk("sat_clear", d, 32'd0);

        // Reset mid-buzz with a read response pending
        axi_write(4'h0, 32'h3, 4'hF, 1'b0);
        axi_write(4'hC, 32'd100, 4'hF, 1'b0);
        pulse();
        tick(); tick();
        chk("pre_rst_buzzer", {31'd0, buzzer}, 32'd1);
        s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
        tick();
        tick();
        s_axi_arvalid = 1'b0;
        chk("pre_rst_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        chk("post_rst_buzzer", {31'd0, buzzer}, 32'd0);
        chk("post_rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        chk("post_rst_rdata", s_axi_rdata, 32'd0);
        chk_outputs("post_rst");
        s_axi_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_resp", {31'd0, s_axi_rvalid}, 32'd0);
        end
        s_axi_rready = 1'b0;
        axi_read(4'h0, d, e);
        chk("post_rst_ctrl", d, 32'd0);
        axi_read(4'hC, d, e);
        chk("post_rst_len", d, BUZZ_RST);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
